// File: rtl/wd_reset_gen.sv
// wd_reset_gen: per-channel watchdog failure counters feeding a shared, retriggerable system reset pulse.
// Latency: EXP[i] rises RST_LMT+1 edges after WDFAIL[i] is first sampled high; RST_ANY/RSTOUT/FIRST_* align with EXP.
// Backpressure: none; inputs are level-sampled every cycle and all outputs are registered status.
module wd_reset_gen #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 16,
  parameter int IDX_W     = $clog2(NCH)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [NCH-1:0]   WDFAIL,
  input  logic [NCH-1:0]   CH_EN,
  input  logic [CNT_W-1:0] RST_LMT,
  input  logic             MODE,
  input  logic             CLR,
  output logic [NCH-1:0]   EXP,
  output logic             RST_ANY,
  output logic             RSTOUT,
  output logic [IDX_W-1:0] FIRST_CH,
  output logic             FIRST_VLD
);

  // Pulse counter must hold PULSE_LEN itself, hence the +1.
  localparam int              PC_W       = $clog2(PULSE_LEN + 1);
  localparam logic [PC_W-1:0] PULSE_LOAD = PC_W'(PULSE_LEN);
  localparam logic [PC_W-1:0] PULSE_ONE  = PC_W'(1);

  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_d;
  logic [NCH-1:0]            exp_d;
  logic [NCH-1:0]            new_exp;
  logic                      new_any;
  logic [IDX_W-1:0]          new_idx;
  logic [PC_W-1:0]           pulse_cnt;

  // Per-channel next state: disable beats healthy beats saturate beats count; CLR then wipes the flags.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      exp_d[i] = EXP[i];
      if (!CH_EN[i]) begin
        cnt_d[i] = '0;
        exp_d[i] = 1'b0;
      end else if (!WDFAIL[i]) begin
        cnt_d[i] = '0;
        if (!MODE) begin
          exp_d[i] = 1'b0;
        end
      end else if (cnt_q[i] >= RST_LMT) begin
        // Counter holds here, so it never wraps even at the maximum limit.
        exp_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // Counters keep running through a clear, so a still-saturated channel re-expires next edge.
    if (CLR) begin
      exp_d = '0;
    end
  end

  // A new expiration is a 0->1 transition that actually survives into EXP.
  assign new_exp = exp_d & ~EXP;
  assign new_any = |new_exp;

  // Lowest-indexed newly expiring channel wins when several expire together.
  always_comb begin
    new_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (new_exp[i]) begin
        new_idx = IDX_W'(i);
      end
    end
  end

  // Channel counters, expired flags and the aligned OR of the flags.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q   <= '0;
      EXP     <= '0;
      RST_ANY <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      EXP     <= exp_d;
      RST_ANY <= |exp_d;
    end
  end

  // Reset pulse: load on any new expiration (retrigger extends), then count down to zero.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pulse_cnt <= '0;
      RSTOUT    <= 1'b0;
    end else if (new_any) begin
      pulse_cnt <= PULSE_LOAD;
      RSTOUT    <= 1'b1;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - PULSE_ONE;
      RSTOUT    <= (pulse_cnt > PULSE_ONE);
    end
  end

  // First-failing-channel record: captured once, dropped on clear or when nothing is expired.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      FIRST_CH  <= '0;
      FIRST_VLD <= 1'b0;
    end else if (CLR || (exp_d == '0)) begin
      FIRST_CH  <= '0;
      FIRST_VLD <= 1'b0;
    end else if (new_any && !FIRST_VLD) begin
      FIRST_CH  <= new_idx;
      FIRST_VLD <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wd_reset_gen.sv
// tb_wd_reset_gen: directed scenarios plus randomized traffic against a behavioural watchdog model.
// Latency: checks every edge, sampling outputs 1 time unit after the rising edge.
// Backpressure: not applicable; the DUT has no flow control.
module tb_wd_reset_gen;

  localparam int NCH       = 4;
  localparam int CNT_W     = 8;
  localparam int PULSE_LEN = 16;
  localparam int IDX_W     = 2;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic [NCH-1:0]   WDFAIL;
  logic [NCH-1:0]   CH_EN;
  logic [CNT_W-1:0] RST_LMT;
  logic             MODE;
  logic             CLR;
  logic [NCH-1:0]   EXP;
  logic             RST_ANY;
  logic             RSTOUT;
  logic [IDX_W-1:0] FIRST_CH;
  logic             FIRST_VLD;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integers, edge-numbered pulse window.
  int m_cnt [NCH];
  bit m_exp [NCH];
  int m_edge;
  int m_pulse_end;
  int m_first;
  bit m_vld;

  wd_reset_gen #(.NCH(NCH), .CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .WDFAIL(WDFAIL), .CH_EN(CH_EN), .RST_LMT(RST_LMT),
    .MODE(MODE), .CLR(CLR), .EXP(EXP), .RST_ANY(RST_ANY), .RSTOUT(RSTOUT),
    .FIRST_CH(FIRST_CH), .FIRST_VLD(FIRST_VLD)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_exp[i] = 1'b0;
    end
    m_edge      = 0;
    m_pulse_end = -1;
    m_first     = 0;
    m_vld       = 1'b0;
  endfunction

  function automatic void model_edge();
    bit prev;
    bit any_new;
    bit any_exp;
    int first_new;
    any_new   = 1'b0;
    any_exp   = 1'b0;
    first_new = -1;
    m_edge++;
    for (int i = 0; i < NCH; i++) begin
      prev = m_exp[i];
      if (!CH_EN[i]) begin
        m_cnt[i] = 0;
        m_exp[i] = 1'b0;
      end else if (!WDFAIL[i]) begin
        m_cnt[i] = 0;
        if (!MODE) m_exp[i] = 1'b0;
      end else if (m_cnt[i] >= int'(RST_LMT)) begin
        m_exp[i] = 1'b1;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
      if (CLR) m_exp[i] = 1'b0;
      if (m_exp[i] && !prev) begin
        any_new = 1'b1;
        if (first_new < 0) first_new = i;
      end
      if (m_exp[i]) any_exp = 1'b1;
    end
    if (any_new) m_pulse_end = m_edge + PULSE_LEN - 1;
    if (!any_exp) begin
      m_vld = 1'b0;
    end else if (any_new && !m_vld) begin
      m_vld   = 1'b1;
      m_first = first_new;
    end
  endfunction

  function automatic logic [NCH-1:0] m_exp_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_exp[i];
    return v;
  endfunction

  function automatic logic m_rstout();
    return (m_edge <= m_pulse_end);
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    RSTN    = 1'b0;
    WDFAIL  = '0;
    CH_EN   = '1;
    CLR     = 1'b0;
    MODE    = 1'b0;
    RST_LMT = 8'd5;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    RSTN = 1'b0;
    #1;
    n_cmp++; if (EXP !== 4'b0000) begin n_err++; $display("FAIL reset_exp: got %b want 0000", EXP); end
    n_cmp++; if (RSTOUT !== 1'b0) begin n_err++; $display("FAIL reset_rstout: got %b want 0", RSTOUT); end
    n_cmp++; if (FIRST_VLD !== 1'b0) begin n_err++; $display("FAIL reset_first_vld: got %b want 0", FIRST_VLD); end
    apply_reset();
    RST_LMT = 8'd0;
    WDFAIL  = 4'b0001;
    repeat (4) tick();
    n_cmp++; if (EXP !== m_exp_vec()) begin n_err++; $display("FAIL midpulse_exp: got %b want %b", EXP, m_exp_vec()); end
    n_cmp++; if (RSTOUT !== 1'b1) begin n_err++; $display("FAIL midpulse_rstout: got %b want 1", RSTOUT); end
    // Assert reset mid-cycle; outputs must clear before the next rising edge.
    #3;
    RSTN = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (EXP !== 4'b0000) begin n_err++; $display("FAIL async_exp: got %b want 0000", EXP); end
    n_cmp++; if (RST_ANY !== 1'b0) begin n_err++; $display("FAIL async_rst_any: got %b want 0", RST_ANY); end
    n_cmp++; if (RSTOUT !== 1'b0) begin n_err++; $display("FAIL async_rstout: got %b want 0", RSTOUT); end
    n_cmp++; if (FIRST_VLD !== 1'b0 || FIRST_CH !== 2'd0) begin n_err++; $display("FAIL async_first: got vld=%b ch=%0d want 0/0", FIRST_VLD, FIRST_CH); end
    @(posedge CLK);
    #1;
    n_cmp++; if (EXP !== 4'b0000 || RSTOUT !== 1'b0) begin n_err++; $display("FAIL held_in_reset: got exp=%b rstout=%b want 0/0", EXP, RSTOUT); end
    RSTN   = 1'b1;
    WDFAIL = '0;
  endtask

  task automatic test_basic();
    logic [NCH-1:0] want;
    apply_reset();
    RST_LMT = 8'd5;
    WDFAIL  = 4'b0100;
    for (int e = 1; e <= 24; e++) begin
      tick();
      want = (e >= 6) ? 4'b0100 : 4'b0000;
      n_cmp++; if (EXP !== want) begin n_err++; $display("FAIL basic_exp e=%0d: got %b want %b", e, EXP, want); end
      n_cmp++; if (EXP !== m_exp_vec()) begin n_err++; $display("FAIL basic_exp_model e=%0d: got %b want %b", e, EXP, m_exp_vec()); end
      n_cmp++; if (RSTOUT !== 1'(e >= 6 && e <= 21)) begin n_err++; $display("FAIL basic_rstout e=%0d: got %b want %b", e, RSTOUT, (e >= 6 && e <= 21)); end
      n_cmp++; if (RST_ANY !== 1'(e >= 6)) begin n_err++; $display("FAIL basic_rst_any e=%0d: got %b", e, RST_ANY); end
      if (e >= 6) begin
        n_cmp++; if (FIRST_VLD !== 1'b1 || FIRST_CH !== 2'd2) begin n_err++; $display("FAIL basic_first e=%0d: got vld=%b ch=%0d want 1/2", e, FIRST_VLD, FIRST_CH); end
      end
    end
    WDFAIL = '0;
    tick();
    n_cmp++; if (EXP !== 4'b0000) begin n_err++; $display("FAIL basic_drop_exp: got %b want 0000", EXP); end
    n_cmp++; if (FIRST_VLD !== 1'b0) begin n_err++; $display("FAIL basic_drop_vld: got %b want 0", FIRST_VLD); end
    n_cmp++; if (RST_ANY !== 1'b0) begin n_err++; $display("FAIL basic_drop_any: got %b want 0", RST_ANY); end
  endtask

  task automatic test_latched_clr();
    apply_reset();
    MODE    = 1'b1;
    RST_LMT = 8'd3;
    WDFAIL  = 4'b0001;
    repeat (4) tick();
    n_cmp++; if (EXP !== 4'b0001) begin n_err++; $display("FAIL latch_expire: got %b want 0001", EXP); end
    n_cmp++; if (FIRST_VLD !== 1'b1 || FIRST_CH !== 2'd0) begin n_err++; $display("FAIL latch_first: got vld=%b ch=%0d want 1/0", FIRST_VLD, FIRST_CH); end
    WDFAIL = '0;
    repeat (20) tick();
    n_cmp++; if (EXP !== 4'b0001) begin n_err++; $display("FAIL latch_hold: got %b want 0001", EXP); end
    n_cmp++; if (RST_ANY !== 1'b1) begin n_err++; $display("FAIL latch_any: got %b want 1", RST_ANY); end
    n_cmp++; if (RSTOUT !== 1'b0) begin n_err++; $display("FAIL latch_pulse_done: got %b want 0", RSTOUT); end
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    n_cmp++; if (EXP !== 4'b0000) begin n_err++; $display("FAIL clr_exp: got %b want 0000", EXP); end
    n_cmp++; if (FIRST_VLD !== 1'b0) begin n_err++; $display("FAIL clr_vld: got %b want 0", FIRST_VLD); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (RSTOUT !== 1'b0 || RSTOUT !== m_rstout()) begin n_err++; $display("FAIL clr_no_pulse k=%0d: got %b want 0", k, RSTOUT); end
    end
  endtask

  task automatic test_retrigger();
    logic [NCH-1:0] want;
    apply_reset();
    RST_LMT = 8'd4;
    WDFAIL  = 4'b1010;
    for (int e = 1; e <= 34; e++) begin
      if (e == 11) WDFAIL[0] = 1'b1;
      tick();
      want = (e < 5) ? 4'b0000 : ((e < 15) ? 4'b1010 : 4'b1011);
      n_cmp++; if (EXP !== want) begin n_err++; $display("FAIL retrig_exp e=%0d: got %b want %b", e, EXP, want); end
      n_cmp++; if (RSTOUT !== 1'(e >= 5 && e <= 30)) begin n_err++; $display("FAIL retrig_rstout e=%0d: got %b want %b", e, RSTOUT, (e >= 5 && e <= 30)); end
      n_cmp++; if (RSTOUT !== m_rstout()) begin n_err++; $display("FAIL retrig_rstout_model e=%0d: got %b want %b", e, RSTOUT, m_rstout()); end
      if (e >= 5) begin
        n_cmp++; if (FIRST_VLD !== 1'b1 || FIRST_CH !== 2'd1) begin n_err++; $display("FAIL retrig_first e=%0d: got vld=%b ch=%0d want 1/1", e, FIRST_VLD, FIRST_CH); end
      end
    end
  endtask

  task automatic test_limits();
    apply_reset();
    RST_LMT = 8'd0;
    WDFAIL  = 4'b1000;
    tick();
    n_cmp++; if (EXP !== 4'b1000) begin n_err++; $display("FAIL lmt0_exp: got %b want 1000", EXP); end
    n_cmp++; if (RSTOUT !== 1'b1) begin n_err++; $display("FAIL lmt0_rstout: got %b want 1", RSTOUT); end
    n_cmp++; if (FIRST_CH !== 2'd3 || FIRST_VLD !== 1'b1) begin n_err++; $display("FAIL lmt0_first: got vld=%b ch=%0d want 1/3", FIRST_VLD, FIRST_CH); end

    apply_reset();
    RST_LMT = 8'd255;
    WDFAIL  = 4'b0001;
    for (int e = 1; e <= 280; e++) begin
      tick();
      n_cmp++; if (EXP[0] !== 1'(e >= 256)) begin n_err++; $display("FAIL lmt255_exp e=%0d: got %b want %b", e, EXP[0], (e >= 256)); end
      n_cmp++; if (RSTOUT !== 1'(e >= 256 && e <= 271)) begin n_err++; $display("FAIL lmt255_rstout e=%0d: got %b", e, RSTOUT); end
    end

    apply_reset();
    RST_LMT = 8'd100;
    WDFAIL  = 4'b0010;
    repeat (50) tick();
    n_cmp++; if (EXP !== 4'b0000) begin n_err++; $display("FAIL lower_pre: got %b want 0000", EXP); end
    RST_LMT = 8'd10;
    tick();
    n_cmp++; if (EXP !== 4'b0010) begin n_err++; $display("FAIL lower_exp: got %b want 0010", EXP); end
    n_cmp++; if (RSTOUT !== 1'b1) begin n_err++; $display("FAIL lower_rstout: got %b want 1", RSTOUT); end
  endtask

  task automatic test_enable();
    apply_reset();
    RST_LMT = 8'd20;
    CH_EN   = 4'b1101;
    WDFAIL  = 4'b0010;
    for (int k = 0; k < 300; k++) begin
      tick();
      n_cmp++; if (EXP !== 4'b0000 || RSTOUT !== 1'b0) begin n_err++; $display("FAIL disabled k=%0d: got exp=%b rstout=%b want 0/0", k, EXP, RSTOUT); end
    end
    CH_EN = 4'b1111;
    for (int e = 1; e <= 22; e++) begin
      tick();
      n_cmp++; if (EXP[1] !== 1'(e >= 21)) begin n_err++; $display("FAIL reenable e=%0d: got %b want %b", e, EXP[1], (e >= 21)); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    RST_LMT = 8'd4;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) RST_LMT = 8'($urandom_range(0, 12));
      for (int i = 0; i < NCH; i++) begin
        if (WDFAIL[i]) begin
          if ($urandom_range(0, 19) == 0) WDFAIL[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 3) == 0) WDFAIL[i] = 1'b1;
        end
        if ($urandom_range(0, 63) == 0) CH_EN[i] = ~CH_EN[i];
      end
      CLR = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) MODE = ~MODE;
      tick();
      n_cmp++; if (EXP !== m_exp_vec()) begin n_err++; $display("FAIL rnd_exp c=%0d: got %b want %b", c, EXP, m_exp_vec()); end
      n_cmp++; if (RST_ANY !== (|m_exp_vec())) begin n_err++; $display("FAIL rnd_any c=%0d: got %b want %b", c, RST_ANY, |m_exp_vec()); end
      n_cmp++; if (RSTOUT !== m_rstout()) begin n_err++; $display("FAIL rnd_rstout c=%0d: got %b want %b", c, RSTOUT, m_rstout()); end
      n_cmp++; if (FIRST_VLD !== m_vld) begin n_err++; $display("FAIL rnd_vld c=%0d: got %b want %b", c, FIRST_VLD, m_vld); end
      if (m_vld) begin
        n_cmp++; if (FIRST_CH !== IDX_W'(m_first)) begin n_err++; $display("FAIL rnd_first c=%0d: got %0d want %0d", c, FIRST_CH, m_first); end
      end
    end
    CLR = 1'b0;
  endtask

  initial begin
    RSTN    = 1'b0;
    WDFAIL  = '0;
    CH_EN   = '1;
    RST_LMT = '0;
    MODE    = 1'b0;
    CLR     = 1'b0;
    test_reset();
    test_basic();
    test_latched_clr();
    test_retrigger();
    test_limits();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
